// File: rtl/mem_pkg.sv
// Shared types for the memory burst reader.
//   access_size_e  : encoding of the memory access_size pins (1/4/8/16 words)
//   reader_state_e : burst reader FSM states
//   burst_len()    : words in a burst for a given access size
package mem_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        SZ_1  = 2'b00,
        SZ_4  = 2'b01,
        SZ_8  = 2'b10,
        SZ_16 = 2'b11
    } access_size_e;

    typedef enum logic [1:0] {
        IDLE,
        BURST,
        DRAIN,
        FLUSH
    } reader_state_e;

    function automatic logic [4:0] burst_len(input access_size_e sz);
        case (sz)
            SZ_1:    return 5'd1;
            SZ_4:    return 5'd4;
            SZ_8:    return 5'd8;
            default: return 5'd16;
        endcase
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO used to hold returned burst words.
//   clk, rst_n : clock, asynchronous active-low reset (clears pointers/count)
//   push       : write wr_data (never issued when full; asserted below)
//   pop        : discard head; ignored when empty
//   rd_data    : head entry (meaningful only when !empty)
//   full/empty : occupancy flags
//   count      : number of stored entries, 0..DEPTH
module sync_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] store [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_pop;

    assign do_pop  = pop && !empty;
    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign rd_data = store[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)   wr_ptr <= wr_ptr + AW'(1);
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            case ({push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: ;
            endcase
        end
    end

    // NOTE: the storage array is deliberately left out of reset; only the
    // pointers and count define which entries are valid, and a resettable
    // array would cost a reset net per bit and block RAM inference.
    always_ff @(posedge clk) begin
        if (push) store[wr_ptr] <= wr_data;
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && full));

endmodule

// File: rtl/mem_burst_reader.sv
// Read-only initiator for the word-addressed burst memory.
// Accepts client read requests, drives the memory request pins, captures the
// returned 1/4/8/16-word burst into a FIFO and streams it back to the client.
//   clk, rst_n         : clock, asynchronous active-low reset
//   req_valid/ready    : request handshake; req_addr (byte address, [1:0]
//                        dropped), req_size (00=1, 01=4, 10=8, 11=16 words)
//   rsp_valid/ready    : response stream; rsp_data word, rsp_last marks the
//                        final word of a burst
//   mem_enable         : memory enable (combinational)
//   mem_rd_wr          : tied to read
//   mem_access_size    : registered burst size
//   mem_addr           : registered word-aligned address
//   mem_data_out       : registered read data from the memory
//   mem_busy           : memory burst in progress
//   proto_err          : sticky flag for memory handshake violations
module mem_burst_reader
    import mem_pkg::*;
#(
    parameter int FIFO_DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [31:0]       req_addr,
    input  logic [1:0]        req_size,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [WORD_W-1:0] rsp_data,
    output logic              rsp_last,
    output logic              mem_enable,
    output logic              mem_rd_wr,
    output logic [1:0]        mem_access_size,
    output logic [31:0]       mem_addr,
    input  logic [WORD_W-1:0] mem_data_out,
    input  logic              mem_busy,
    output logic              proto_err
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] FIFO_FULL = CW'(FIFO_DEPTH);

    reader_state_e     state;
    access_size_e      size_q;
    logic [4:0]        cnt;
    logic [4:0]        n_len;
    logic [4:0]        req_len;
    logic              cap_pend;
    logic              cap_last;
    logic [CW-1:0]     fifo_count;
    logic [CW-1:0]     free_slots;
    logic              fifo_full;
    logic              fifo_empty;
    logic [WORD_W:0]   fifo_head;

    assign n_len      = burst_len(size_q);
    assign req_len    = burst_len(access_size_e'(req_size));
    assign free_slots = FIFO_FULL - fifo_count;

    // Only one burst is ever in flight, so current occupancy alone decides
    // whether the whole next burst is guaranteed to fit.
    assign req_ready = (state == IDLE) && !mem_busy && !fifo_full &&
                       (free_slots >= CW'(req_len));

    // In FLUSH the enable tracks busy so stale words are clocked out without
    // ever presenting an idle-memory edge, which would start a new access.
    assign mem_enable      = (state == BURST) || (state == FLUSH && mem_busy);
    assign mem_rd_wr       = 1'b1;
    assign mem_access_size = size_q;

    // NOTE: every register in this block uses non-blocking assignment so all
    // next-state values are computed from the pre-edge state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            size_q    <= SZ_1;
            mem_addr  <= '0;
            cnt       <= '0;
            cap_pend  <= 1'b0;
            cap_last  <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            cap_pend <= 1'b0;
            cap_last <= 1'b0;
            case (state)
                IDLE: begin
                    if (mem_busy) begin
                        state <= FLUSH;
                    end else if (req_valid && req_ready) begin
                        mem_addr <= req_addr & 32'hFFFF_FFFC;
                        size_q   <= access_size_e'(req_size);
                        cnt      <= '0;
                        state    <= BURST;
                    end
                end
                BURST: begin
                    // Word cnt becomes visible after this edge; capture it
                    // on the following edge.
                    cap_pend <= 1'b1;
                    cap_last <= (cnt == n_len - 5'd1);
                    cnt      <= cnt + 5'd1;
                    if (cnt != 5'd0 && !mem_busy) proto_err <= 1'b1;
                    if (cnt == n_len - 5'd1) state <= DRAIN;
                end
                DRAIN: begin
                    if (mem_busy) proto_err <= 1'b1;
                    state <= IDLE;
                end
                FLUSH: begin
                    if (!mem_busy) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    sync_fifo #(
        .WIDTH (WORD_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (cap_pend),
        .wr_data ({cap_last, mem_data_out}),
        .pop     (rsp_ready),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // Head fields are masked while empty so the stream reads as zero then.
    assign rsp_valid = !fifo_empty;
    assign rsp_data  = fifo_empty ? '0 : fifo_head[WORD_W-1:0];
    assign rsp_last  = !fifo_empty && fifo_head[WORD_W];

endmodule

// File: tb/tb_mem_burst_reader.sv
// Self-checking bench for mem_burst_reader: behavioural burst memory,
// scoreboard of expected response words, directed and random traffic.
module tb_mem_burst_reader;

    localparam int          FIFO_DEPTH = 16;
    localparam logic [31:0] BASE       = 32'h8002_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic [1:0]  req_size = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_data;
    logic        rsp_last;
    logic        mem_enable;
    logic        mem_rd_wr;
    logic [1:0]  mem_access_size;
    logic [31:0] mem_addr;
    logic [31:0] mem_data_out;
    logic        mem_busy;
    logic        proto_err;

    always #5 clk = ~clk;

    mem_burst_reader #(.FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_addr        (req_addr),
        .req_size        (req_size),
        .rsp_valid       (rsp_valid),
        .rsp_ready       (rsp_ready),
        .rsp_data        (rsp_data),
        .rsp_last        (rsp_last),
        .mem_enable      (mem_enable),
        .mem_rd_wr       (mem_rd_wr),
        .mem_access_size (mem_access_size),
        .mem_addr        (mem_addr),
        .mem_data_out    (mem_data_out),
        .mem_busy        (mem_busy),
        .proto_err       (proto_err)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Words in a burst: 1 for size 0, otherwise 2^(size+1).
    function automatic int ref_len(input logic [1:0] sz);
        int s;
        s = int'(sz);
        return (s == 0) ? 1 : (1 << (s + 1));
    endfunction

    // ---------------- behavioural memory ----------------
    logic [31:0] mem_img [256];
    logic        m_busy = 1'b0;
    logic [31:0] m_dout = '0;
    logic [7:0]  m_idx0 = '0;
    int          m_k = 0;
    int          m_n = 1;
    int          m_reqs = 0;
    logic [31:0] m_last_addr = '0;
    logic [1:0]  m_last_size = '0;
    logic        kill = 1'b0;

    // Pin values captured mid-cycle, used by the memory on the next edge.
    logic        s_en = 1'b0;
    logic        s_rdwr = 1'b1;
    logic [31:0] s_addr = '0;
    logic [1:0]  s_size = '0;

    assign mem_busy     = m_busy && !kill;
    assign mem_data_out = m_dout;

    always @(posedge clk) begin
        if (s_en) begin
            if (!m_busy) begin
                if (s_rdwr) begin
                    m_idx0      <= s_addr[9:2];
                    m_k         <= 0;
                    m_n         <= ref_len(s_size);
                    m_dout      <= mem_img[s_addr[9:2]];
                    m_busy      <= (ref_len(s_size) > 1);
                    m_reqs      <= m_reqs + 1;
                    m_last_addr <= s_addr;
                    m_last_size <= s_size;
                end
            end else begin
                m_dout <= mem_img[m_idx0 + 8'(m_k + 1)];
                m_k    <= m_k + 1;
                if (m_k + 1 == m_n - 1) m_busy <= 1'b0;
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    logic [32:0] exp_q[$];
    int          pop_cyc[$];
    int          cyc = 0;
    int          en_cnt = 0;
    int          exp_en = 0;
    int          accept_cnt = 0;
    int          pops = 0;
    int          write_seen = 0;
    logic [31:0] last_pop_data = '0;

    always @(negedge clk) begin : monitor
        int          n;
        logic [7:0]  idx;
        logic [32:0] e;
        s_en   = mem_enable;
        s_rdwr = mem_rd_wr;
        s_addr = mem_addr;
        s_size = mem_access_size;
        cyc++;
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            if (mem_enable) en_cnt++;
            if (mem_enable && !mem_busy && !mem_rd_wr) write_seen++;
            if (req_valid && req_ready) begin
                n   = ref_len(req_size);
                idx = req_addr[9:2];
                for (int k = 0; k < n; k++)
                    exp_q.push_back({k == n - 1, mem_img[idx + 8'(k)]});
                accept_cnt++;
                exp_en += n;
            end
            if (rsp_valid && rsp_ready) begin
                pops++;
                pop_cyc.push_back(cyc);
                last_pop_data = rsp_data;
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 32'(rsp_valid), 0);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_data", rsp_data, e[31:0]);
                    check("rsp_last", 32'(rsp_last), 32'(e[32]));
                end
            end
        end
    end

    // ---------------- driver helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request until accepted; returns how many mid-cycle samples
    // it took (1 = accepted on the first edge).
    task automatic issue(input logic [31:0] a, input logic [1:0] sz, input int budget,
                         output int waited);
        logic ok;
        ok = 1'b0;
        waited = 0;
        req_valid = 1'b1;
        req_addr  = a;
        req_size  = sz;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            waited++;
            if (req_ready) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        tick();
        req_valid = 1'b0;
        if (!ok) check("accept_timeout", 32'(req_ready), 1);
    endtask

    task automatic wait_idle(input string tag);
        logic done;
        done = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !rsp_valid) begin
                done = 1'b1;
                break;
            end
            tick();
        end
        if (!done) check({tag, "_drain_timeout"}, exp_q.size() + int'(rsp_valid), 0);
        tick();
        tick();
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

    // ---------------- test sequence ----------------
    initial begin : main
        int e0, x0, p0, w, lat;
        logic acc;
        for (int i = 0; i < 256; i++) mem_img[i] = $urandom;

        // Reset state
        tick();
        tick();
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_rsp_last", 32'(rsp_last), 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_proto_err", 32'(proto_err), 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_size", 32'(mem_access_size), 0);
        check("rst_mem_enable", 32'(mem_enable), 0);
        rst_n = 1'b1;
        tick();
        @(negedge clk);
        check("idle_req_ready", 32'(req_ready), 1);
        tick();

        // Single word
        rsp_ready = 1'b1;
        e0 = en_cnt;
        p0 = pops;
        issue(BASE, 2'b00, 10, w);
        lat = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            lat++;
            if (rsp_valid) break;
            tick();
        end
        check("single_latency", lat, 3);
        wait_idle("single");
        check("single_en_cycles", en_cnt - e0, 1);
        check("single_beats", pops - p0, 1);
        check("single_data", last_pop_data, mem_img[0]);

        // 4-word burst
        e0 = en_cnt;
        p0 = pops;
        pop_cyc.delete();
        issue(BASE + 32'h10, 2'b01, 10, w);
        wait_idle("burst4");
        check("burst4_en_cycles", en_cnt - e0, 4);
        check("burst4_beats", pops - p0, 4);
        check("burst4_consecutive", (pop_cyc.size() == 4) ? pop_cyc[3] - pop_cyc[0] : -1, 3);
        check("burst4_last_data", last_pop_data, mem_img[7]);
        check("burst4_mem_addr", m_last_addr, BASE + 32'h10);
        check("burst4_mem_size", 32'(m_last_size), 1);
        check("burst4_proto_err", 32'(proto_err), 0);

        // Back-pressure: fill the FIFO, then a 1-word request must wait
        rsp_ready = 1'b0;
        p0 = pops;
        issue(BASE + 32'h100, 2'b11, 10, w);
        repeat (20) tick();
        @(negedge clk);
        check("bp_rsp_valid", 32'(rsp_valid), 1);
        tick();
        req_valid = 1'b1;
        req_addr  = BASE + 32'h40;
        req_size  = 2'b00;
        lat = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (req_ready) lat++;
            tick();
        end
        req_valid = 1'b0;
        check("bp_ready_while_full", lat, 0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        issue(BASE + 32'h40, 2'b00, 10, w);
        check("bp_accept_after_pop", w, 1);
        rsp_ready = 1'b1;
        wait_idle("bp");
        check("bp_total_beats", pops - p0, 17);
        check("bp_last_data", last_pop_data, mem_img[16]);

        // Misaligned address
        issue(BASE + 32'h7, 2'b00, 10, w);
        check("misalign_mem_addr", mem_addr, BASE + 32'h4);
        wait_idle("misalign");
        check("misalign_data", last_pop_data, mem_img[1]);

        // Random traffic
        e0 = en_cnt;
        x0 = exp_en;
        for (int c = 0; c < 900; c++) begin
            rsp_ready = ($urandom_range(0, 3) != 0);
            if (!req_valid && c < 800 && $urandom_range(0, 2) == 0) begin
                req_valid = 1'b1;
                req_addr  = BASE + ($urandom_range(0, 255) << 2) + $urandom_range(0, 3);
                req_size  = 2'($urandom_range(0, 3));
            end
            @(negedge clk);
            acc = req_valid && req_ready;
            tick();
            if (acc) req_valid = 1'b0;
        end
        check("rand_req_retired", 32'(req_valid), 0);
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        wait_idle("rand");
        check("rand_en_cycles", en_cnt - e0, exp_en - x0);
        check("rand_proto_err", 32'(proto_err), 0);

        // Reset after 3 of 16 beats
        issue(BASE + 32'h200, 2'b11, 10, w);
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("mid_rst_rsp_valid", 32'(rsp_valid), 0);
        check("mid_rst_rsp_data", rsp_data, 0);
        check("mid_rst_mem_addr", mem_addr, 0);
        check("mid_rst_mem_size", 32'(mem_access_size), 0);
        check("mid_rst_mem_enable", 32'(mem_enable), 0);
        tick();
        rst_n = 1'b1;
        e0 = en_cnt;
        lat = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (!mem_busy && req_ready) begin
                lat = 1;
                break;
            end
            tick();
        end
        check("flush_back_to_idle", lat, 1);
        tick();
        check("flush_en_cycles", en_cnt - e0, 13);
        issue(BASE + 32'h30, 2'b01, 10, w);
        wait_idle("post_flush");
        check("post_flush_data", last_pop_data, mem_img[15]);
        check("mem_req_count", m_reqs, accept_cnt);

        // Busy dropped mid-burst
        issue(BASE + 32'h50, 2'b01, 10, w);
        tick();
        tick();
        kill = 1'b1;
        tick();
        kill = 1'b0;
        wait_idle("fault");
        check("fault_proto_err", 32'(proto_err), 1);
        issue(BASE, 2'b00, 10, w);
        wait_idle("fault_sticky");
        check("fault_proto_sticky", 32'(proto_err), 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        @(negedge clk);
        check("fault_proto_cleared", 32'(proto_err), 0);
        check("final_req_ready", 32'(req_ready), 1);
        check("no_memory_writes", write_seen, 0);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
